// File: rtl/mips_pkg.sv
// Shared core definitions: multiplier width, counter width and FSM state encoding.
package mips_pkg;
    localparam int unsigned MULT_W = 32;
    localparam int unsigned CNT_W  = $clog2(MULT_W);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/multu_step.sv
// One radix-2 shift-add iteration of the unsigned multiplier.
module multu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   a_q,
    output logic [2*WIDTH-1:0] acc_nxt
);
    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    always_comb begin
        addend  = acc[0] ? {1'b0, a_q} : '0;
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
        // The carry out of the add shifts into the top bit of the accumulator.
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/multu_unit.sv
// Iterative unsigned multiplier with architectural HI/LO and pipeline stall request.
module multu_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_W
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CW-1:0]      cnt;

    multu_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .a_q     (a_q),
        .acc_nxt (acc_nxt)
    );

    // Control FSM, iteration counter and HI/LO result registers.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        a_q   <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    // HI/LO stay stable until the final step publishes the product.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= acc_nxt[2*WIDTH-1:WIDTH];
                        lo    <= acc_nxt[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stall = busy & (start | rd_req);
endmodule

// File: tb/tb_multu_unit.sv
// Self-checking bench for multu_unit against a plain-arithmetic product model.
module tb_multu_unit;
    logic        Clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    multu_unit #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .rd_req  (rd_req),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Runs one multiply from acceptance to the done cycle, checking every cycle.
    task automatic run_mult(input logic [31:0] ta, input logic [31:0] tb_op,
                            input logic rd, input string name);
        logic [63:0] prod;
        prod   = 64'(ta) * 64'(tb_op);
        start  = 1'b1;
        a      = ta;
        b      = tb_op;
        rd_req = rd;
        #1;
        n_checks++;
        if ({busy, stall, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL %s accept: busy/stall/hi/lo=%b/%b/%h/%h want 0/0/%h/%h",
                     name, busy, stall, hi, lo, exp_hi, exp_lo);
        end
        next_cycle();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        for (int k = 1; k <= 32; k++) begin
            #1;
            n_checks++;
            if ({busy, done, stall, hi, lo} !== {1'b1, 1'b0, rd, exp_hi, exp_lo}) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: busy/done/stall/hi/lo=%b/%b/%b/%h/%h want 1/0/%b/%h/%h",
                         name, k, busy, done, stall, hi, lo, rd, exp_hi, exp_lo);
            end
            next_cycle();
        end
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        #1;
        n_checks++;
        if ({busy, done, stall, hi, lo} !== {1'b0, 1'b1, 1'b0, exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL %s done cycle: busy/done/stall/hi/lo=%b/%b/%b/%h/%h want 0/1/0/%h/%h",
                     name, busy, done, stall, hi, lo, exp_hi, exp_lo);
        end
        rd_req = 1'b0;
        next_cycle();
        n_checks++;
        if ({busy, done, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL %s after done: busy/done/hi/lo=%b/%b/%h/%h want 0/0/%h/%h",
                     name, busy, done, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        rd_req  = 1'b0;
        a       = '0;
        b       = '0;
        exp_hi  = '0;
        exp_lo  = '0;
        repeat (3) next_cycle();
        n_checks++;
        if ({busy, done, stall, hi, lo} !== 67'b0) begin
            n_fail++;
            $display("FAIL reset state: busy/done/stall/hi/lo=%b/%b/%b/%h/%h want all zero",
                     busy, done, stall, hi, lo);
        end
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic();
        run_mult(32'd3, 32'd5, 1'b0, "basic_3x5");
        n_checks++;
        if ({hi, lo} !== 64'h0000_0000_0000_000F) begin
            n_fail++;
            $display("FAIL basic_value: hi/lo=%h/%h want 00000000/0000000f", hi, lo);
        end
    endtask

    task automatic test_max();
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max");
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL max_value: hi/lo=%h/%h want fffffffe/00000001", hi, lo);
        end
    endtask

    task automatic test_carry();
        run_mult(32'h8000_0000, 32'd2, 1'b0, "carry");
        n_checks++;
        if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL carry_value: hi/lo=%h/%h want 00000001/00000000", hi, lo);
        end
    endtask

    task automatic test_stall();
        run_mult($urandom, $urandom, 1'b1, "stall_rd");
        for (int k = 0; k < 3; k++) begin
            rd_req = 1'b1;
            #1;
            n_checks++;
            if (stall !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_rd_stall: stall=%b want 0", stall);
            end
            next_cycle();
        end
        rd_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] p1;
        logic [31:0] a1;
        logic [31:0] b1;
        a1     = $urandom;
        b1     = $urandom;
        p1     = 64'(a1) * 64'(b1);
        start  = 1'b1;
        a      = a1;
        b      = b1;
        rd_req = 1'b0;
        next_cycle();
        a = 32'h0001_0000;
        b = 32'h0001_0000;
        for (int k = 1; k <= 32; k++) begin
            n_checks++;
            if ({busy, done, stall, hi, lo} !== {1'b1, 1'b0, 1'b1, exp_hi, exp_lo}) begin
                n_fail++;
                $display("FAIL b2b first busy %0d: busy/done/stall/hi/lo=%b/%b/%b/%h/%h want 1/0/1/%h/%h",
                         k, busy, done, stall, hi, lo, exp_hi, exp_lo);
            end
            next_cycle();
        end
        exp_hi = p1[63:32];
        exp_lo = p1[31:0];
        n_checks++;
        if ({busy, done, stall, hi, lo} !== {1'b0, 1'b1, 1'b0, exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL b2b first done: busy/done/stall/hi/lo=%b/%b/%b/%h/%h want 0/1/0/%h/%h",
                     busy, done, stall, hi, lo, exp_hi, exp_lo);
        end
        next_cycle();
        start = 1'b0;
        for (int k = 34; k <= 65; k++) begin
            #1;
            n_checks++;
            if ({busy, done, hi, lo} !== {1'b1, 1'b0, exp_hi, exp_lo}) begin
                n_fail++;
                $display("FAIL b2b second busy cycle %0d: busy/done/hi/lo=%b/%b/%h/%h want 1/0/%h/%h",
                         k, busy, done, hi, lo, exp_hi, exp_lo);
            end
            next_cycle();
        end
        exp_hi = 32'h0000_0001;
        exp_lo = 32'h0000_0000;
        n_checks++;
        if ({busy, done, hi, lo} !== {1'b0, 1'b1, exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL b2b second done cycle 66: busy/done/hi/lo=%b/%b/%h/%h want 0/1/%h/%h",
                     busy, done, hi, lo, exp_hi, exp_lo);
        end
        next_cycle();
    endtask

    task automatic test_mid_reset();
        start  = 1'b1;
        a      = $urandom;
        b      = $urandom;
        rd_req = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (9) next_cycle();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset pre: busy=%b want 1", busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        n_checks++;
        if ({busy, done, stall, hi, lo} !== 67'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy/done/stall/hi/lo=%b/%b/%b/%h/%h want all zero",
                     busy, done, stall, hi, lo);
        end
        rd_req = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        run_mult(32'd7, 32'd6, 1'b0, "after_reset_7x6");
        n_checks++;
        if (lo !== 32'd42) begin
            n_fail++;
            $display("FAIL after_reset_lo: lo=%0d want 42", lo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_mult($urandom, $urandom, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_max();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_carry();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
